lsu_seq: RTL
============

Name: lsu_seq

Overview:
- Load/store sequencer directly upstream of the byte-wide data memory.
- Accepts byte or halfword load/store requests from the core and owns the memory's single address/write port.
- Serialises halfword accesses into two byte accesses, little-endian, and returns load data with a one-cycle response pulse.

Parameters:
- W, 8: memory byte width in bits; request/response data is 2*W.
- A, 8: memory address width; address arithmetic wraps modulo 2**A.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted at 0).
- ReqValid  input  1  core presents a request.
- ReqReady  output  1  sequencer can accept; request accepted on ReqValid && ReqReady at rising Clk.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqHalf  input  1  1 = halfword (2 bytes), 0 = byte.
- ReqAddr  input  A  byte address of the low byte.
- ReqWData  input  2*W  store data; byte store uses [W-1:0].
- RespValid  output  1  one-cycle pulse: access complete.
- RespData  output  2*W  load data, zero-extended for byte loads; 0 for stores.
- Fault  output  1  qualified by RespValid; misaligned halfword (see Optional Feature).
- MemWriteEn  output  1  to memory write enable.
- MemAddress  output  A  to memory address.
- MemDataIn  output  W  to memory write data.
- MemDataOut  input  W  from memory; combinational read of MemAddress.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP. Reset forces IDLE asynchronously.
- Reset values: ReqReady=1, RespValid=0, RespData=0, Fault=0, MemWriteEn=0, MemAddress=0, MemDataIn=0. Internal address/data registers clear to 0.
- IDLE: ReqReady=1. On accept, latch ReqWrite, ReqHalf, ReqAddr, ReqWData, then go to ACC0. ReqReady=0 in every other state.
- ACC0:
  - MemAddress = latched addr; MemDataIn = wdata[W-1:0]; MemWriteEn = latched write.
  - On a load, capture MemDataOut into the low byte at the clock edge.
  - Next state: ACC1 if half, else RESP.
- ACC1:
  - MemAddress = (addr+1) mod 2**A, so 0xFF wraps to 0x00.
  - MemDataIn = wdata[2W-1:W]; MemWriteEn = latched write.
  - On a load, capture MemDataOut into the high byte.
  - Next state: RESP.
- RESP:
  - RespValid=1 for exactly one cycle.
  - RespData = assembled load data; upper byte 0 for byte loads; 0 for stores.
  - Next state: IDLE.
- RespData holds its value until the next RESP. RespValid and Fault are registered outputs.
- MemWriteEn is combinational from state and the latched write flag; it is never high in IDLE or RESP.
- Outside ACC0/ACC1, MemAddress holds the latched addr and MemDataIn holds 0.
- Latency from the accept edge T:
  - byte op: memory access in cycle T+1, RespValid in cycle T+2;
  - halfword: accesses in T+1 and T+2, RespValid in T+3.
- Next accept edge is no earlier than RespValid+1.
- ReqValid while ReqReady=0 is ignored; the core holds the request until accepted.
- Reset mid-operation: MemWriteEn drops immediately. A partially written halfword stays partial; no response is issued.
- No backpressure on responses; the core must sample RespValid every cycle.

Optional Feature:
- Macro: LSU_SEQ_MISALIGN_TRAP_EN.
- Defined: a halfword request with ReqAddr[0]=1 performs no memory access. State goes IDLE -> RESP directly, so RespValid is in cycle T+1 with Fault=1 and RespData=0.
- Not defined: Fault is tied to 0. Odd-address halfwords proceed normally, including wrap from 2**A-1 to 0.

Test Plan:
- Byte store Addr=0x10, WData=0x00A5 -> MemWriteEn high exactly one cycle (T+1) at 0x10 with MemDataIn=0xA5; RespValid at T+2 with RespData=0x0000.
- Halfword store 0x1234 to 0x20, then halfword load 0x20 -> memory holds [0x20]=0x34, [0x21]=0x12; load RespValid at T+3 with RespData=0x1234.
- Byte load of 0x20 after the previous step -> RespData=0x0034, upper byte zero.
- Halfword load at 0xFF (macro undefined) with [0xFF]=0xCD, [0x00]=0xAB -> MemAddress sequence 0xFF then 0x00; RespData=0xABCD, Fault=0.
- Halfword request at 0x21 with LSU_SEQ_MISALIGN_TRAP_EN defined -> no MemWriteEn and no address change to 0x22; RespValid at T+1, Fault=1, RespData=0.
- Reset low during ACC1 of a halfword store -> MemWriteEn=0 and ReqReady=1 asynchronously; no RespValid; the next request is accepted on the first edge after release.

Source files
------------

// File: rtl/lsu_seq_if.sv
// Core-side request/response and memory-side byte port of the load/store sequencer.
// The sequencer connects through the slave modport; core and memory sit on the master side.
interface lsu_seq_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic           ReqValid;
    logic           ReqReady;
    logic           ReqWrite;
    logic           ReqHalf;
    logic [A-1:0]   ReqAddr;
    logic [2*W-1:0] ReqWData;
    logic           RespValid;
    logic [2*W-1:0] RespData;
    logic           Fault;
    logic           MemWriteEn;
    logic [A-1:0]   MemAddress;
    logic [W-1:0]   MemDataIn;
    logic [W-1:0]   MemDataOut;

    modport slave (
        input  ReqValid, ReqWrite, ReqHalf, ReqAddr, ReqWData, MemDataOut,
        output ReqReady, RespValid, RespData, Fault, MemWriteEn, MemAddress, MemDataIn
    );

    modport master (
        output ReqValid, ReqWrite, ReqHalf, ReqAddr, ReqWData, MemDataOut,
        input  ReqReady, RespValid, RespData, Fault, MemWriteEn, MemAddress, MemDataIn
    );
endinterface

// File: rtl/lsu_seq.sv
// Load/store sequencer: splits halfword requests into two little-endian byte accesses.
// Define LSU_SEQ_MISALIGN_TRAP_EN to fault odd-address halfwords instead of serving them.
module lsu_seq #(
    parameter int W = 8,
    parameter int A = 8
) (
    input logic        Clk,
    input logic        Reset,
    lsu_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t         state, state_nxt;
    logic           wr_q, half_q;
    logic [A-1:0]   addr_q;
    logic [2*W-1:0] wdata_q;
    logic [W-1:0]   rdata_lo_q;
    logic           resp_valid_q;
    logic [2*W-1:0] resp_data_q, resp_data_nxt;
    logic           accept;
    logic           trap;

    assign accept = (state == IDLE) && bus.ReqValid;

`ifdef LSU_SEQ_MISALIGN_TRAP_EN
    logic fault_q;
    assign trap = bus.ReqHalf && bus.ReqAddr[0];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) fault_q <= 1'b0;
        else        fault_q <= accept && trap;
    end
    assign bus.Fault = fault_q;
`else
    assign trap      = 1'b0;
    assign bus.Fault = 1'b0;
`endif

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        resp_data_nxt = resp_data_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = trap ? RESP : ACC0;
                    if (trap) resp_data_nxt = '0;
                end
            end
            ACC0: begin
                state_nxt = half_q ? ACC1 : RESP;
                if (!half_q) resp_data_nxt = wr_q ? '0 : {{W{1'b0}}, bus.MemDataOut};
            end
            ACC1: begin
                state_nxt     = RESP;
                resp_data_nxt = wr_q ? '0 : {bus.MemDataOut, rdata_lo_q};
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            wr_q         <= 1'b0;
            half_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_lo_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state        <= state_nxt;
            resp_valid_q <= (state_nxt == RESP);
            resp_data_q  <= resp_data_nxt;
            if (accept) begin
                wr_q    <= bus.ReqWrite;
                half_q  <= bus.ReqHalf;
                addr_q  <= bus.ReqAddr;
                wdata_q <= bus.ReqWData;
            end
            if (state == ACC0 && !wr_q) rdata_lo_q <= bus.MemDataOut;
        end
    end

    // Memory port is decoded straight from state so an asynchronous reset drops the write at once.
    always_comb begin
        bus.MemWriteEn = 1'b0;
        bus.MemAddress = addr_q;
        bus.MemDataIn  = '0;
        unique case (state)
            ACC0: begin
                bus.MemWriteEn = wr_q;
                bus.MemDataIn  = wdata_q[W-1:0];
            end
            ACC1: begin
                bus.MemWriteEn = wr_q;
                bus.MemAddress = addr_q + A'(1);
                bus.MemDataIn  = wdata_q[2*W-1:W];
            end
            default: ;
        endcase
    end

    assign bus.ReqReady  = (state == IDLE);
    assign bus.RespValid = resp_valid_q;
    assign bus.RespData  = resp_data_q;
endmodule
